// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe: valid/ready on the operand side and on the result side.
// master drives operands and out_ready; slave is the arithmetic pipe.
interface addsub_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, dataa, datab, op, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero
  );

  modport slave (
    input  in_valid, dataa, datab, op, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined wrap/saturating add-sub with carry/ovf/zero flags; latency STAGES cycles, one beat per cycle.
// A held output (out_valid && !out_ready) freezes the whole pipe and drops in_ready in the same cycle.
module addsub_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  addsub_pipe_if.slave   bus
);
  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    logic             zero;
  } stage_t;

  stage_t pipe [STAGES];
  stage_t s1_nxt;

  logic             stall;
  logic             is_sub;
  logic             is_sat;
  logic [WIDTH:0]   raw;
  logic             ovf_c;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] res_c;

  assign stall       = pipe[STAGES-1].vld && !bus.out_ready;
  assign bus.in_ready = !stall;

  assign is_sub = bus.op[0];
  assign is_sat = bus.op[1];

  // Unsigned (WIDTH+1)-bit arithmetic: the top bit is carry for add, borrow for subtract.
  assign raw = is_sub ? ({1'b0, bus.dataa} - {1'b0, bus.datab})
                      : ({1'b0, bus.dataa} + {1'b0, bus.datab});

  assign ovf_c = is_sub
      ? ((bus.dataa[MSB] != bus.datab[MSB]) && (raw[MSB] != bus.dataa[MSB]))
      : ((bus.dataa[MSB] == bus.datab[MSB]) && (raw[MSB] != bus.dataa[MSB]));

  // On signed overflow the true result lies beyond the limit on the side of A's sign.
  assign sat_val = bus.dataa[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};

  assign res_c = (is_sat && ovf_c) ? sat_val : raw[WIDTH-1:0];

  always_comb begin
    s1_nxt       = '0;
    s1_nxt.vld   = bus.in_valid;
    s1_nxt.res   = res_c;
    s1_nxt.carry = raw[WIDTH];
    s1_nxt.ovf   = ovf_c;
    s1_nxt.zero  = (res_c == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe[i] <= '0;
      end
    end else if (!stall) begin
      pipe[0] <= s1_nxt;
      for (int i = 1; i < STAGES; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign bus.out_valid = pipe[STAGES-1].vld;
  assign bus.result    = pipe[STAGES-1].res;
  assign bus.carry     = pipe[STAGES-1].carry;
  assign bus.ovf       = pipe[STAGES-1].ovf;
  assign bus.zero      = pipe[STAGES-1].zero;
endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: directed vectors on an 8-bit/2-stage unit, plus random sweeps
// on 16-bit/1-stage and 4-bit/4-stage units checked against an integer reference model.
module tb_addsub_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_lat8 = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t q4[$];

  addsub_pipe_if #(.WIDTH(8))  if8 ();
  addsub_pipe_if #(.WIDTH(16)) if16 ();
  addsub_pipe_if #(.WIDTH(4))  if4 ();

  addsub_pipe #(.WIDTH(8),  .STAGES(2)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  addsub_pipe #(.WIDTH(16), .STAGES(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  addsub_pipe #(.WIDTH(4),  .STAGES(4)) dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations; returns {res, c, v, z}.
  function automatic logic [18:0] ref_op(input int w, input int a, input int b, input logic [1:0] op);
    int full, mx, mn, sa, sb, us, ss, res;
    logic c, v;
    full = 1 << w;
    mx   = (1 << (w - 1)) - 1;
    mn   = -(1 << (w - 1));
    sa   = (a > mx) ? a - full : a;
    sb   = (b > mx) ? b - full : b;
    us   = op[0] ? a - b : a + b;
    ss   = op[0] ? sa - sb : sa + sb;
    c    = op[0] ? (a < b) : (us >= full);
    v    = (ss > mx) || (ss < mn);
    res  = us & (full - 1);
    if (op[1] && v) res = (ss > mx) ? mx : (mn & (full - 1));
    return {16'(res), c, v, (res == 0)};
  endfunction

  // Monitors: compare whenever a result beat transfers.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && if8.out_valid && if8.out_ready) begin
      chk("q8_has_beat", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("out8", 32'({if8.result, if8.carry, if8.ovf, if8.zero}), 32'({e.res[7:0], e.c, e.v, e.z}));
        if (chk_lat8) chk("lat8", 32'(cyc - e.cyc), 32'd2);
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_n && if16.out_valid && if16.out_ready) begin
      chk("q16_has_beat", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        chk("out16", 32'({if16.result, if16.carry, if16.ovf, if16.zero}), 32'({e.res, e.c, e.v, e.z}));
        chk("lat16", 32'(cyc - e.cyc), 32'd1);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && if4.out_valid && if4.out_ready) begin
      chk("q4_has_beat", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("out4", 32'({if4.result, if4.carry, if4.ovf, if4.zero}), 32'({e.res[3:0], e.c, e.v, e.z}));
        chk("lat4", 32'(cyc - e.cyc), 32'd4);
      end
    end
  end

  // Called just after a rising edge; holds the beat until accepted, pushing the expectation on acceptance.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [7:0] r, input logic c, input logic v, input logic z);
    bit acc = 1'b0;
    if8.in_valid = 1'b1;
    if8.dataa    = a;
    if8.datab    = b;
    if8.op       = op;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (if8.in_ready) begin
        acc = 1'b1;
        q8.push_back('{res: 16'(r), c: c, v: v, z: z, cyc: cyc});
      end
      @(posedge clk);
      #1;
    end
    if8.in_valid = 1'b0;
    chk("send8_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && (q8.size() + q16.size() + q4.size()) != 0; i++) @(posedge clk);
    #1;
    chk(name, 32'(q8.size() + q16.size() + q4.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [18:0] m;
    int a, b;
    logic [1:0] o;
    if8.in_valid = 0;  if8.dataa = 0;  if8.datab = 0;  if8.op = 0;  if8.out_ready = 1;
    if16.in_valid = 0; if16.dataa = 0; if16.datab = 0; if16.op = 0; if16.out_ready = 1;
    if4.in_valid = 0;  if4.dataa = 0;  if4.datab = 0;  if4.op = 0;  if4.out_ready = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_outputs", 32'({if8.result, if8.carry, if8.ovf, if8.zero}), 32'd0);
    chk("rst_out_valid4", 32'(if4.out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(if8.in_ready), 32'd1);
    chk("rst_out_valid_rel", 32'(if8.out_valid), 32'd0);

    // Directed vectors, back to back at full throughput
    send8(8'h01, 8'h01, 2'b00, 8'h02, 0, 0, 0);
    send8(8'hFF, 8'h01, 2'b00, 8'h00, 1, 0, 1);
    send8(8'h00, 8'h01, 2'b01, 8'hFF, 1, 0, 0);
    send8(8'h7F, 8'h01, 2'b10, 8'h7F, 0, 1, 0);
    send8(8'h80, 8'h01, 2'b11, 8'h80, 0, 1, 0);
    send8(8'h7F, 8'h01, 2'b00, 8'h80, 0, 1, 0);
    send8(8'h05, 8'h05, 2'b11, 8'h00, 0, 0, 1);
    send8(8'h80, 8'hFF, 2'b10, 8'h80, 1, 1, 0);
    send8(8'h03, 8'h05, 2'b01, 8'hFE, 1, 0, 0);
    send8(8'h7F, 8'hFF, 2'b11, 8'h7F, 1, 1, 0);
    send8(8'h40, 8'h40, 2'b01, 8'h00, 0, 0, 1);
    drain("drain_directed");

    // Backpressure: stream 1..6 and stall 3 cycles once the first result is valid
    chk_lat8 = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) send8(8'(k), 8'h00, 2'b00, 8'(k), 0, 0, 0);
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(posedge clk);
          #1;
          seen = if8.out_valid;
        end
        chk("bp_first_valid", 32'(seen), 32'd1);
        if8.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(if8.in_ready), 32'd0);
          chk("bp_held", 32'({if8.out_valid, if8.result}), 32'h101);
          @(posedge clk);
          #1;
        end
        if8.out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    chk_lat8 = 1'b1;

    // Parameter sweep on the 16/1 and 4/4 units
    for (int k = 0; k < 24; k++) begin
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      o = 2'($urandom_range(0, 3));
      if16.in_valid = 1'b1; if16.dataa = 16'(a); if16.datab = 16'(b); if16.op = o;
      if4.in_valid = 1'b1;  if4.dataa = 4'(a);   if4.datab = 4'(b);   if4.op = ~o;
      @(negedge clk);
      if (if16.in_ready) begin
        m = ref_op(16, a, b, o);
        q16.push_back('{res: m[18:3], c: m[2], v: m[1], z: m[0], cyc: cyc});
      end
      if (if4.in_ready) begin
        m = ref_op(4, a & 15, b & 15, ~o);
        q4.push_back('{res: m[18:3], c: m[2], v: m[1], z: m[0], cyc: cyc});
      end
      @(posedge clk);
      #1;
    end
    if16.in_valid = 1'b0;
    if4.in_valid  = 1'b0;
    drain("drain_sweep");

    // Reset with two beats in flight
    if8.out_ready = 1'b0;
    send8(8'h11, 8'h01, 2'b00, 8'h12, 0, 0, 0);
    send8(8'h22, 8'h01, 2'b00, 8'h23, 0, 0, 0);
    #2;
    chk("pre_rst_valid", 32'(if8.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_valid", 32'(if8.out_valid), 32'd0);
    q8.delete();
    if8.out_ready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("rst_rel_in_ready", 32'(if8.in_ready), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("no_stale_beat", 32'(if8.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send8(8'h10, 8'h20, 2'b00, 8'h30, 0, 0, 0);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
